// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the single register-file write port.
// Each requester owns a one-entry slot; full slots drain round-robin, one write per cycle.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Req0_Valid_i,
    input  logic [ADDR_WIDTH-1:0]     Req0_Addr_i,
    input  logic [DATA_WIDTH-1:0]     Req0_Data_i,
    output logic                      Req0_Ready_o,
    input  logic                      Req1_Valid_i,
    input  logic [ADDR_WIDTH-1:0]     Req1_Addr_i,
    input  logic [DATA_WIDTH-1:0]     Req1_Data_i,
    output logic                      Req1_Ready_o,
    output logic                      Reg_Write_o,
    output logic [ADDR_WIDTH-1:0]     Write_Register_o,
    output logic [DATA_WIDTH-1:0]     Write_Data_o,
    output logic                      Grant_o,
    output logic [2**ADDR_WIDTH-1:0]  Pending_o
);
    localparam int NUM_REGS = 2**ADDR_WIDTH;

    typedef struct packed {
        logic                  full;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } slot_t;

    slot_t                 slot [2];
    logic                  last_grant;
    logic [1:0]            valid;
    logic [1:0]            ready;
    logic [1:0]            grant;
    logic [ADDR_WIDTH-1:0] req_addr [2];
    logic [DATA_WIDTH-1:0] req_data [2];

    assign valid       = {Req1_Valid_i, Req0_Valid_i};
    assign req_addr[0] = Req0_Addr_i;
    assign req_addr[1] = Req1_Addr_i;
    assign req_data[0] = Req0_Data_i;
    assign req_data[1] = Req1_Data_i;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant = 2'b00;
        if (slot[0].full && slot[1].full)
            grant = last_grant ? 2'b01 : 2'b10;
        else if (slot[0].full)
            grant = 2'b01;
        else if (slot[1].full)
            grant = 2'b10;
    end

    always_comb begin
        ready = 2'b00;
        for (int n = 0; n < 2; n++)
            ready[n] = reset && (!slot[n].full || grant[n]);
    end

    assign Req0_Ready_o = ready[0];
    assign Req1_Ready_o = ready[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int n = 0; n < 2; n++)
                slot[n] <= '0;
            last_grant       <= 1'b1;
            Reg_Write_o      <= 1'b0;
            Write_Register_o <= '0;
            Write_Data_o     <= '0;
            Grant_o          <= 1'b0;
        end else begin
            // Writes to r0 complete the handshake but are dropped here.
            for (int n = 0; n < 2; n++) begin
                if (valid[n] && ready[n] && req_addr[n] != '0)
                    slot[n] <= '{full: 1'b1, addr: req_addr[n], data: req_data[n]};
                else if (grant[n])
                    slot[n].full <= 1'b0;
            end
            if (|grant) begin
                Reg_Write_o      <= 1'b1;
                Write_Register_o <= grant[1] ? slot[1].addr : slot[0].addr;
                Write_Data_o     <= grant[1] ? slot[1].data : slot[0].data;
                Grant_o          <= grant[1];
                last_grant       <= grant[1];
            end else begin
                Reg_Write_o      <= 1'b0;
                Write_Register_o <= '0;
                Write_Data_o     <= '0;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_pending
        assign Pending_o[k] = (slot[0].full && slot[0].addr == ADDR_WIDTH'(k)) ||
                              (slot[1].full && slot[1].addr == ADDR_WIDTH'(k));
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: requester 0 (ALU/immediate path) and requester 1 (load/multi-cycle path).
- Each requester has a one-entry holding slot. Full slots are granted round-robin, at most one register write per cycle.
- Drives the register-file write address, data and enable; the address feeds the 5-to-32 write-enable decoder.
- Exports a 32-bit pending-write bitmask for hazard detection.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, width of register address; register count is 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- Req0_Valid_i  input  1  requester 0 has a write.
- Req0_Addr_i  input  ADDR_WIDTH  requester 0 destination register.
- Req0_Data_i  input  DATA_WIDTH  requester 0 write data.
- Req0_Ready_o  output  1  requester 0 slot can accept.
- Req1_Valid_i  input  1  requester 1 has a write.
- Req1_Addr_i  input  ADDR_WIDTH  requester 1 destination register.
- Req1_Data_i  input  DATA_WIDTH  requester 1 write data.
- Req1_Ready_o  output  1  requester 1 slot can accept.
- Reg_Write_o  output  1  register-file write enable, registered.
- Write_Register_o  output  ADDR_WIDTH  write address, registered.
- Write_Data_o  output  DATA_WIDTH  write data, registered.
- Grant_o  output  1  source of the current write (0 or 1), registered.
- Pending_o  output  2**ADDR_WIDTH  bit k=1 while a full slot targets register k.

Behaviour:
- Reset (reset=0 at a rising edge): both slots empty, last_grant=1 (so requester 0 wins the first contention), Reg_Write_o=0, Write_Register_o=0, Write_Data_o=0, Grant_o=0.
- While reset is low, ReqN_Ready_o=0. Reset mid-operation discards slot contents; no write is issued for them.
- Handshake: a transfer occurs on a rising edge where ReqN_Valid_i=1 and ReqN_Ready_o=1.
  - Valid/Addr/Data must stay stable until accepted.
  - ReqN_Ready_o = !slotN_full OR slotN granted this cycle, so one slot sustains one write per cycle.
- Address 0: the handshake completes but the slot is not loaded. No write is issued and no pending bit is set.
- Arbitration, combinational on slot state each cycle:
  - Only one slot full: grant it.
  - Both full: grant the requester != last_grant.
  - last_grant updates on every grant.
- Output stage:
  - On the edge after a grant: Reg_Write_o=1, Write_Register_o/Write_Data_o = slot contents, Grant_o = winner, and the granted slot empties (unless refilled on the same edge).
  - No grant: Reg_Write_o=0, Write_Register_o=0, Write_Data_o=0; Grant_o holds its value.
  - Reg_Write_o is high exactly one cycle per granted entry.
- Latency (uncontended): Valid in cycle C0 -> slot full and Pending bit set in C1 -> Reg_Write_o=1 in C2 with the Pending bit cleared.
- Contention: the loser waits one cycle per competing grant. Its Ready_o stays 0 while its slot is full and not granted.
- Worst-case wait is 1 cycle.
- Ordering: entries from the same requester are written in acceptance order. Entries from different requesters follow grant order.
- Same address in both slots: no merging. Both are written in grant order, and the pending bit stays set until both are drained.
- Pending_o = onehot(slot0.addr)&slot0_full OR onehot(slot1.addr)&slot1_full. This is combinational from slot state. Bit 0 is always 0.
- Simultaneous grant and refill of the same slot: the new entry is loaded and the old entry is issued. The pending bit reflects the new entry.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with both Valid=1, addr 9 -> Ready_o=0, Reg_Write_o=0, Pending_o=0. After release: Ready=1, first write addr 9 from requester 0 (Grant_o=0).
2. Single write: Req0 addr 5, data 0xDEADBEEF, valid in C0 only -> C1: Pending_o=0x00000020. C2: Reg_Write_o=1, Write_Register_o=5, Write_Data_o=0xDEADBEEF, Pending_o=0. C3: Reg_Write_o=0.
3. Streaming: Req0 Valid held 4 cycles, addrs 1,2,3,4 -> Ready_o stays 1; writes to 1,2,3,4 in C2..C5 back-to-back.
4. Contention: both Valid continuously, Req0 addr 3 / Req1 addr 7 -> Reg_Write_o=1 every cycle from C2. Addresses alternate 3,7,3,7; Grant_o alternates 0,1,0,1.
5. Register 0: Req1 addr 0, data 0x1234 -> handshake completes, Reg_Write_o stays 0, Pending_o stays 0.
6. Reset mid-operation: both slots full (addrs 10, 11), reset=0 for one edge -> next cycle Pending_o=0, Reg_Write_o=0, and no write to 10 or 11 ever appears.
